ps2_rx_fifo: RTL

Parametrised PS/2 keyboard receiver that replaces the single-register scancode/flag receiver.
- Filters ps2clk and deserialises 11-bit frames with full start/parity/stop checking.
- Decodes E0 (extended) and F0 (break) prefixes and reports both make and break events.
- Buffers decoded events in a show-ahead FIFO, so a consumer such as the VGA colour controller can drain keys at its own pace.
- Runs on the pixel-clock domain between the keyboard pins and the display logic.

---
 rtl/ps2_rx_fifo.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver with event FIFO.
// Filters the raw keyboard clock, deserialises 11-bit frames, folds E0/F0
// prefixes into make/break events and queues them in a show-ahead FIFO.
module ps2_rx_fifo #(
  parameter int FILTER_LEN = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int AW         = 3,
  parameter int TIMEOUT    = 2500
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ps2clk,
  input  logic          ps2data,
  input  logic          rd_en,
  input  logic          clr_err,
  output logic [7:0]    code,
  output logic          brk,
  output logic          ext,
  output logic          valid,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          frame_err
);

  localparam int SRW = 2 * FILTER_LEN;
  localparam int TW  = $clog2(TIMEOUT + 1);

  logic            clk_s1, clk_s2, data_s1, data_s2;
  logic [SRW-1:0]  filt_sr;
  logic            fall_edge;
  logic [3:0]      bitcnt;
  logic [9:0]      shreg;
  logic [TW-1:0]   to_cnt;
  logic            at_stop, frame_good, bad_stop, timeout_hit;
  logic            byte_valid;
  logic [7:0]      byte_reg;
  logic            ext_pend, brk_pend;
  logic            push, do_push, do_pop, full;
  logic [9:0]      push_data, head;
  logic [9:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;

  // Two-flop synchronisers; reset to the idle-high line level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2data;
      data_s2 <= data_s1;
    end
  end

  // Glitch filter history of synced ps2clk; all ones means an idle line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) filt_sr <= '1;
    else       filt_sr <= {filt_sr[SRW-2:0], clk_s2};
  end

  assign fall_edge = (&filt_sr[SRW-1:FILTER_LEN]) && ~(|filt_sr[FILTER_LEN-1:0]);

  // Frame-level decisions made in the stop-bit cycle and on timeout
  always_comb begin
    at_stop     = fall_edge && (bitcnt == 4'd10);
    frame_good  = ~shreg[0] & data_s2 & (^shreg[9:1]);
    bad_stop    = at_stop & ~frame_good;
    timeout_hit = (bitcnt != 4'd0) && !fall_edge && (to_cnt == TW'(TIMEOUT));
  end

  // Bit counter and shift register; bits enter at the top so the start bit ends at bit 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bitcnt <= 4'd0;
      shreg  <= '0;
    end else if (timeout_hit) begin
      bitcnt <= 4'd0;
    end else if (fall_edge) begin
      if (bitcnt == 4'd10) begin
        bitcnt <= 4'd0;
      end else begin
        bitcnt <= bitcnt + 4'd1;
        shreg  <= {data_s2, shreg[9:1]};
      end
    end
  end

  // Inter-edge timer; only runs while a frame is partially received
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        to_cnt <= '0;
    else if (fall_edge || bitcnt == 4'd0 || timeout_hit) to_cnt <= '0;
    else                                              to_cnt <= to_cnt + 1'b1;
  end

  // Register the completed byte and the error pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_valid <= 1'b0;
      byte_reg   <= 8'h00;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= at_stop & frame_good;
      frame_err  <= bad_stop | timeout_hit;
      if (at_stop) byte_reg <= shreg[8:1];
    end
  end

  // Prefix tracking; any error or timeout forgets a pending prefix
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (bad_stop || timeout_hit) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (byte_valid) begin
      if (byte_reg == 8'hE0) begin
        ext_pend <= 1'b1;
      end else if (byte_reg == 8'hF0) begin
        brk_pend <= 1'b1;
      end else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

  // Push/pop qualification; a full FIFO still accepts a push when popping
  always_comb begin
    push      = byte_valid && (byte_reg != 8'hE0) && (byte_reg != 8'hF0);
    push_data = {ext_pend, brk_pend, byte_reg};
    full      = count[AW];
    do_pop    = rd_en && valid;
    do_push   = push && (!full || do_pop);
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !do_pop) overflow <= 1'b1;
      else if (clr_err)            overflow <= 1'b0;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign valid = (count != '0);
  assign head  = mem[rd_ptr];

  // Show-ahead head outputs, forced to zero while empty
  always_comb begin
    code = 8'h00;
    brk  = 1'b0;
    ext  = 1'b0;
    if (valid) begin
      code = head[7:0];
      brk  = head[8];
      ext  = head[9];
    end
  end

endmodule
